// File: rtl/xdatabus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : xdatabus_arbiter
//  Brief    : Round-robin arbiter sharing one DMA native databus port between
//             N_REQ databus masters. A granted requester owns the port for a
//             full burst of len+1 beats, after which priority rotates to the
//             next index.
//  Revision : 1.0 - initial release
// ============================================================================
module xdatabus_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 32,
    parameter int DATABUS_W = 256,
    parameter int LEN_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ*ADDR_W-1:0]        req_addr,
    input  logic [N_REQ*DATABUS_W-1:0]     req_wdata,
    input  logic [N_REQ*DATABUS_W/8-1:0]   req_wstrb,
    input  logic [N_REQ*LEN_W-1:0]         req_len,
    output logic [N_REQ-1:0]               req_ready,
    output logic [DATABUS_W-1:0]           req_rdata,
    output logic                           m_valid,
    output logic [ADDR_W-1:0]              m_addr,
    output logic [DATABUS_W-1:0]           m_wdata,
    output logic [DATABUS_W/8-1:0]         m_wstrb,
    output logic [LEN_W-1:0]               m_len,
    input  logic [DATABUS_W-1:0]           m_rdata,
    input  logic                           m_ready,
    output logic [$clog2(N_REQ)-1:0]       grant,
    output logic                           busy
);

    localparam int C_GRANT_W = $clog2(N_REQ);
    localparam int C_STRB_W  = DATABUS_W / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [C_GRANT_W-1:0]   r_ptr;
    logic [C_GRANT_W-1:0]   w_ptr_nxt;
    logic [C_GRANT_W-1:0]   r_grant;
    logic [C_GRANT_W-1:0]   w_grant_nxt;
    logic [LEN_W-1:0]       r_len_q;
    logic [LEN_W-1:0]       w_len_nxt;
    logic [LEN_W:0]         r_beat_cnt;
    logic [LEN_W:0]         w_beat_nxt;
    logic [C_GRANT_W-1:0]   w_sel;
    logic                   w_sel_found;
    logic                   w_beat;
    logic [C_GRANT_W-1:0]   w_grant_inc;

    // Per-requester views of the flattened request buses
    logic [ADDR_W-1:0]      w_addr_a  [N_REQ];
    logic [DATABUS_W-1:0]   w_wdata_a [N_REQ];
    logic [C_STRB_W-1:0]    w_wstrb_a [N_REQ];
    logic [LEN_W-1:0]       w_len_a   [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_a[gi] = req_wdata[gi*DATABUS_W +: DATABUS_W];
        assign w_wstrb_a[gi] = req_wstrb[gi*C_STRB_W +: C_STRB_W];
        assign w_len_a[gi]   = req_len[gi*LEN_W +: LEN_W];
    end

    // Round-robin pick: first valid index at or after r_ptr, wrapping.
    // Scanning from the far end lets the entry nearest r_ptr win last.
    always_comb begin : p_select
        logic [C_GRANT_W:0] v_idx;
        w_sel_found = 1'b0;
        w_sel       = '0;
        v_idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_idx = {1'b0, r_ptr} + (C_GRANT_W+1)'(k);
            if (v_idx >= (C_GRANT_W+1)'(N_REQ)) begin
                v_idx = v_idx - (C_GRANT_W+1)'(N_REQ);
            end
            if (req_valid[v_idx[C_GRANT_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel       = v_idx[C_GRANT_W-1:0];
            end
        end
    end

    // Priority moves to the requester right after the finishing owner
    assign w_grant_inc = (r_grant == C_GRANT_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

    // Next-state logic and port muxing for the two-state grant FSM
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_len_nxt   = r_len_q;
        w_beat_nxt  = r_beat_cnt;
        w_beat      = 1'b0;
        busy        = 1'b0;
        m_valid     = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_len       = r_len_q;
        req_ready   = '0;
        req_rdata   = m_rdata;

        case (r_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_sel;
                    w_len_nxt   = w_len_a[w_sel];
                    w_beat_nxt  = '0;
                end
            end
            ST_BUSY: begin
                busy               = 1'b1;
                m_valid            = req_valid[r_grant];
                m_addr             = w_addr_a[r_grant];
                m_wdata            = w_wdata_a[r_grant];
                m_wstrb            = w_wstrb_a[r_grant];
                req_ready[r_grant] = m_ready;
                w_beat             = req_valid[r_grant] & m_ready;
                if (w_beat) begin
                    w_beat_nxt = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == {1'b0, r_len_q}) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = w_grant_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and burst bookkeeping registers; reset and clear both abort
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_len_q    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_len_q    <= w_len_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    assign grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_xdatabus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xdatabus_arbiter
//  Brief    : Self-checking bench for xdatabus_arbiter with a burst-level
//             reference model and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xdatabus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int LW = 8;
    localparam int SW = DW / 8;
    localparam int GW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_wstrb;
    logic [N*LW-1:0]   req_len;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     req_rdata;
    logic              m_valid;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic [LW-1:0]     m_len;
    logic [DW-1:0]     m_rdata;
    logic              m_ready;
    logic [GW-1:0]     grant;
    logic              busy;

    logic [AW-1:0]     t_addr  [N];
    logic [DW-1:0]     t_wdata [N];
    logic [SW-1:0]     t_wstrb [N];
    logic [LW-1:0]     t_len   [N];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_addr[gi*AW +: AW]  = t_addr[gi];
        assign req_wdata[gi*DW +: DW] = t_wdata[gi];
        assign req_wstrb[gi*SW +: SW] = t_wstrb[gi];
        assign req_len[gi*LW +: LW]   = t_len[gi];
    end

    xdatabus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATABUS_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_len(req_len), .req_ready(req_ready),
        .req_rdata(req_rdata), .m_valid(m_valid), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_len(m_len),
        .m_rdata(m_rdata), .m_ready(m_ready), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: owner + beats remaining ----------------
    bit mdl_busy  = 1'b0;
    int mdl_owner = 0;
    int mdl_ptr   = 0;
    int mdl_left  = 0;
    int mdl_lenq  = 0;

    always @(posedge clk) begin : p_model
        bit found;
        int g;
        if (!rst || clear) begin
            mdl_busy = 1'b0; mdl_owner = 0; mdl_ptr = 0; mdl_left = 0; mdl_lenq = 0;
        end else if (!mdl_busy) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                g = (mdl_ptr + k) % N;
                if (!found && req_valid[g]) begin
                    found     = 1'b1;
                    mdl_busy  = 1'b1;
                    mdl_owner = g;
                    mdl_lenq  = int'(t_len[g]);
                    mdl_left  = int'(t_len[g]) + 1;
                end
            end
        end else if (req_valid[mdl_owner] && m_ready) begin
            mdl_left = mdl_left - 1;
            if (mdl_left == 0) begin
                mdl_busy = 1'b0;
                mdl_ptr  = (mdl_owner + 1) % N;
            end
        end
    end

    logic          exp_busy;
    logic          exp_mvalid;
    logic [N-1:0]  exp_ready;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [SW-1:0] exp_wstrb;
    logic [LW-1:0] exp_len;
    logic [GW-1:0] exp_grant;

    always_comb begin
        exp_busy   = mdl_busy;
        exp_mvalid = 1'b0;
        exp_ready  = '0;
        exp_addr   = '0;
        exp_wdata  = '0;
        exp_wstrb  = '0;
        exp_len    = LW'(mdl_lenq);
        exp_grant  = GW'(mdl_owner);
        if (mdl_busy) begin
            exp_mvalid           = req_valid[mdl_owner];
            exp_ready[mdl_owner] = m_ready;
            exp_addr             = t_addr[mdl_owner];
            exp_wdata            = t_wdata[mdl_owner];
            exp_wstrb            = t_wstrb[mdl_owner];
        end
    end

    // ---------------- helpers (timing only, no checks) ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        m_ready   = 1'b0;
        m_rdata   = '0;
        for (int i = 0; i < N; i++) begin
            t_addr[i]  = AW'(32'h1000_0000 + 32'(i) * 32'h100);
            t_wdata[i] = {8{32'hA5A5_0000 + 32'(i)}};
            t_wstrb[i] = '0;
            t_len[i]   = '0;
        end
    endtask

    task automatic reset_dut();
        rst   = 1'b0;
        clear = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; clear = 1'b0;
        idle_inputs();
        req_valid = '1;
        m_ready   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            n_cmp++;
            if (m_valid !== 1'b0 || req_ready !== 3'b000 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outputs: m_valid=%b req_ready=%b busy=%b, required 0/000/0",
                         m_valid, req_ready, busy);
            end
        end
        rst = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (busy !== 1'b1 || grant !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_first_grant: busy=%b grant=%0d, required 1/0", busy, grant);
        end
    endtask

    task automatic test_single_burst();
        int  beats = 0;
        bit  seen  = 1'b0;
        bit  done  = 1'b0;
        reset_dut();
        t_len[0]  = 8'd3;
        req_valid = 3'b001;
        m_ready   = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (m_valid && req_ready[0]) beats++;
            n_cmp++;
            if (req_ready[2:1] !== 2'b00) begin
                n_bad++;
                $display("FAIL single_other_ready: req_ready=%b, required bits[2:1]=00", req_ready);
            end
            if (busy) seen = 1'b1;
            if (seen && !busy) done = 1'b1;
            else tick();
        end
        n_cmp++;
        if (beats != 4 || !done) begin
            n_bad++;
            $display("FAIL single_beats: beats=%0d done=%0b, required 4/1", beats, done);
        end
        req_valid = '1;
        tick();
        #1;
        n_cmp++;
        if (grant !== 2'd1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_ptr_next: grant=%0d busy=%b, required 1/1", grant, busy);
        end
    endtask

    task automatic test_rotation();
        int  exp_seq [4] = '{0, 1, 2, 0};
        int  got     = 0;
        int  idle_n  = 0;
        bit  prev_b  = 1'b0;
        reset_dut();
        req_valid = '1;
        m_ready   = 1'b1;
        for (int c = 0; c < 30 && got < 4; c++) begin
            #1;
            if (busy && !prev_b) begin
                n_cmp++;
                if (int'(grant) != exp_seq[got]) begin
                    n_bad++;
                    $display("FAIL rotation_grant[%0d]: grant=%0d, required %0d", got, grant, exp_seq[got]);
                end
                if (got > 0) begin
                    n_cmp++;
                    if (idle_n != 1) begin
                        n_bad++;
                        $display("FAIL rotation_idle_gap[%0d]: idle=%0d, required 1", got, idle_n);
                    end
                end
                got++;
            end
            idle_n = busy ? 0 : idle_n + 1;
            prev_b = busy;
            tick();
        end
        n_cmp++;
        if (got != 4) begin
            n_bad++;
            $display("FAIL rotation_count: grants=%0d, required 4", got);
        end
    endtask

    task automatic test_stall();
        int  beats     = 0;
        int  stall_cnt = 0;
        bit  stalled   = 1'b0;
        bit  seen      = 1'b0;
        bit  done      = 1'b0;
        reset_dut();
        t_len[1] = 8'd7;
        m_ready  = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            req_valid = (stall_cnt > 0) ? 3'b000 : 3'b010;
            #1;
            if (m_valid && req_ready[1]) beats++;
            if (stall_cnt > 0) begin
                n_cmp++;
                if (m_valid !== 1'b0 || busy !== 1'b1 || grant !== 2'd1 || req_ready !== 3'b010) begin
                    n_bad++;
                    $display("FAIL stall_hold: m_valid=%b busy=%b grant=%0d req_ready=%b, required 0/1/1/010",
                             m_valid, busy, grant, req_ready);
                end
                stall_cnt--;
            end
            if (beats == 2 && !stalled) begin
                stalled   = 1'b1;
                stall_cnt = 5;
            end
            if (busy) seen = 1'b1;
            if (seen && !busy) done = 1'b1;
            else tick();
        end
        n_cmp++;
        if (beats != 8 || !done) begin
            n_bad++;
            $display("FAIL stall_beats: beats=%0d done=%0b, required 8/1", beats, done);
        end
    endtask

    task automatic test_clear();
        int beats = 0;
        reset_dut();
        t_len[0]  = 8'd255;
        req_valid = 3'b001;
        m_ready   = 1'b1;
        for (int c = 0; c < 30 && beats < 10; c++) begin
            #1;
            if (m_valid && req_ready[0]) beats++;
            if (beats < 10) tick();
        end
        clear = 1'b1;
        tick();
        clear     = 1'b0;
        req_valid = '1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || req_ready !== 3'b000) begin
            n_bad++;
            $display("FAIL clear_idle: busy=%b m_valid=%b req_ready=%b, required 0/0/000",
                     busy, m_valid, req_ready);
        end
        tick();
        #1;
        n_cmp++;
        if (busy !== 1'b1 || grant !== 2'd0) begin
            n_bad++;
            $display("FAIL clear_ptr_zero: busy=%b grant=%0d, required 1/0", busy, grant);
        end
    endtask

    task automatic test_max_len();
        int beats = 0;
        bit seen  = 1'b0;
        bit done  = 1'b0;
        reset_dut();
        t_len[2]  = 8'd255;
        req_valid = 3'b100;
        m_ready   = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (m_valid && req_ready[2]) beats++;
            if (busy) seen = 1'b1;
            if (seen && !busy) done = 1'b1;
            else tick();
        end
        n_cmp++;
        if (beats != 256 || !done) begin
            n_bad++;
            $display("FAIL max_len_beats: beats=%0d done=%0b, required 256/1", beats, done);
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        bit seen  = 1'b0;
        bit done  = 1'b0;
        reset_dut();
        t_len[0]  = 8'd5;
        req_valid = 3'b001;
        for (int c = 0; c < 40 && !done; c++) begin
            m_ready = c[0];
            if (seen) t_len[0] = LW'($urandom);
            #1;
            if (m_valid && m_ready && req_ready[0]) beats++;
            if (busy) begin
                seen = 1'b1;
                n_cmp++;
                if (m_len !== 8'd5) begin
                    n_bad++;
                    $display("FAIL backpressure_m_len: m_len=%0d, required 5", m_len);
                end
            end
            if (seen && !busy) done = 1'b1;
            else tick();
        end
        n_cmp++;
        if (beats != 6 || !done) begin
            n_bad++;
            $display("FAIL backpressure_beats: beats=%0d done=%0b, required 6/1", beats, done);
        end
    endtask

    task automatic test_random();
        int   cur_beats = 0;
        bit   was_busy  = 1'b0;
        bit   was_abort = 1'b0;
        int   was_len   = 0;
        reset_dut();
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(3) != 0);
                t_len[i]     = LW'($urandom_range(7));
                t_addr[i]    = AW'($urandom);
                t_wdata[i]   = {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom};
                t_wstrb[i]   = SW'($urandom);
            end
            m_ready = ($urandom_range(2) != 0);
            m_rdata = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
            clear   = ($urandom_range(149) == 0);
            #1;
            n_cmp++;
            if (busy !== exp_busy || m_valid !== exp_mvalid || req_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL rand_ctrl@%0d: busy=%b m_valid=%b req_ready=%b, required %b/%b/%b",
                         c, busy, m_valid, req_ready, exp_busy, exp_mvalid, exp_ready);
            end
            n_cmp++;
            if (exp_busy && grant !== exp_grant) begin
                n_bad++;
                $display("FAIL rand_grant@%0d: grant=%0d, required %0d", c, grant, exp_grant);
            end
            n_cmp++;
            if (m_addr !== exp_addr || m_wstrb !== exp_wstrb || m_len !== exp_len) begin
                n_bad++;
                $display("FAIL rand_mux@%0d: addr=%h strb=%h len=%0d, required %h/%h/%0d",
                         c, m_addr, m_wstrb, m_len, exp_addr, exp_wstrb, exp_len);
            end
            n_cmp++;
            if (m_wdata !== exp_wdata || req_rdata !== m_rdata) begin
                n_bad++;
                $display("FAIL rand_data@%0d: wdata/rdata differ from selected requester/DMA", c);
            end
            if (was_busy && !exp_busy && !was_abort) begin
                n_cmp++;
                if (cur_beats != was_len + 1) begin
                    n_bad++;
                    $display("FAIL rand_burst_beats@%0d: beats=%0d, required %0d", c, cur_beats, was_len + 1);
                end
            end
            if (!exp_busy) cur_beats = 0;
            if (m_valid && m_ready) cur_beats++;
            was_busy  = exp_busy;
            was_len   = int'(exp_len);
            was_abort = clear;
            tick();
        end
        clear = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        clear = 1'b0;
        idle_inputs();
        test_reset();
        test_single_burst();
        test_rotation();
        test_stall();
        test_clear();
        test_max_len();
        test_backpressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
